// File: rtl/fib_pkg.sv
// Shared definitions for the triangular-sum checker: default width,
// checker FSM states and the multiplier iteration count.
package fib_pkg;

  localparam int unsigned W_DEF     = 11;
  localparam int unsigned MUL_ITERS = W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } fib_state_e;

endpackage

// File: rtl/seq_shift_add_mul.sv
// Sequential W x W -> 2W shift-add multiplier, one multiplier bit per cycle, LSB first.
// `done` strobes during the final iteration, so `prod` is complete on the following cycle.
module seq_shift_add_mul
  import fib_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned ITERS = MUL_ITERS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int unsigned CW = $clog2(ITERS) + 1;

  logic [2*W-1:0] mcand_q, mcand_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           last_s;

  assign last_s = busy_q && (cnt_q == CW'(ITERS - 1));

  // Next-state for operand load and one shift-add iteration
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = {{W{1'b0}}, a};
      mplier_d = b;
      prod_d   = {(2*W){1'b0}};
      cnt_d    = {CW{1'b0}};
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end else begin
        prod_d = prod_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      busy_d   = ~last_s;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Multiplier state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= {(2*W){1'b0}};
      mplier_q <= {W{1'b0}};
      prod_q   <= {(2*W){1'b0}};
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = last_s;
  assign prod = prod_q;

endmodule

// File: rtl/fib_sum_checker.sv
// Checks a triangular-sum accumulator: per-cycle step legality, then the final
// sum against n*(n-1)/2 mod 2^W computed by a sequential multiplier.
module fib_sum_checker
  import fib_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i,
  input  logic [W-1:0] n,
  input  logic [W-1:0] c,
  output logic         done,
  output logic         pass,
  output logic         fail,
  output logic [W-1:0] expected,
  output logic         step_err
);

  fib_state_e     state_q, state_d;
  logic [W-1:0]   c_cap_q, c_cap_d;
  logic [W-1:0]   expected_q, expected_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic           fail_q, fail_d;
  logic [W-1:0]   i_prev_q, i_prev_d;
  logic [W-1:0]   c_prev_q, c_prev_d;
  logic           prev_vld_q, prev_vld_d;
  logic           step_err_q, step_err_d;

  logic [W-1:0]   i_inc_s;
  logic [W-1:0]   c_sum_s;
  logic           step_ok_s;
  logic [W-1:0]   n_dec_s;
  logic [W-1:0]   half_prod_s;
  logic           mul_start_s;
  logic           mul_busy_s;
  logic           mul_last_s;
  logic [2*W-1:0] mul_prod_s;
  logic           unused_s;

  assign n_dec_s     = n - {{(W-1){1'b0}}, 1'b1};
  assign half_prod_s = mul_prod_s[W:1];
  assign unused_s    = ^{mul_busy_s, mul_prod_s[2*W-1:W+1], mul_prod_s[0]};

  seq_shift_add_mul #(
    .W     (W),
    .ITERS (W)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start_s),
    .a     (n),
    .b     (n_dec_s),
    .busy  (mul_busy_s),
    .done  (mul_last_s),
    .prod  (mul_prod_s)
  );

  // Step monitor: a hold or a single accumulation step is legal, anything else latches an error
  always_comb begin
    i_inc_s    = i_prev_q + {{(W-1){1'b0}}, 1'b1};
    c_sum_s    = c_prev_q + i_prev_q;
    step_ok_s  = ((i == i_prev_q) && (c == c_prev_q)) ||
                 ((i == i_inc_s)  && (c == c_sum_s));
    i_prev_d   = i;
    c_prev_d   = c;
    prev_vld_d = 1'b1;
    if (prev_vld_q && !step_ok_s) begin
      step_err_d = 1'b1;
    end else begin
      step_err_d = step_err_q;
    end
  end

  // Checker FSM next-state; outputs freeze once DONE is reached
  always_comb begin
    state_d     = state_q;
    c_cap_d     = c_cap_q;
    expected_d  = expected_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    mul_start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (i >= n) begin
          c_cap_d     = c;
          mul_start_s = 1'b1;
          state_d     = MUL;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (mul_last_s) begin
          state_d = CMP;
        end else begin
          state_d = MUL;
        end
      end
      CMP: begin
        expected_d = half_prod_s;
        pass_d     = (c_cap_q == half_prod_s);
        fail_d     = (c_cap_q != half_prod_s);
        done_d     = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All checker registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      c_cap_q    <= {W{1'b0}};
      expected_q <= {W{1'b0}};
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      i_prev_q   <= {W{1'b0}};
      c_prev_q   <= {W{1'b0}};
      prev_vld_q <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_cap_q    <= c_cap_d;
      expected_q <= expected_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      i_prev_q   <= i_prev_d;
      c_prev_q   <= c_prev_d;
      prev_vld_q <= prev_vld_d;
      step_err_q <= step_err_d;
    end
  end

  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign expected = expected_q;
  assign step_err = step_err_q;

endmodule

// File: tb/tb_fib_sum_checker.sv
// Scoreboard bench for fib_sum_checker: drives accumulator sequences and
// compares final results and step errors against a closed-form model.
module tb_fib_sum_checker;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] i, n, c;
  logic         done, pass, fail, step_err;
  logic [W-1:0] expected;

  typedef struct {
    string        tag;
    logic [W-1:0] exp_val;
    logic         exp_pass;
    logic         exp_serr;
  } sb_t;

  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic bad_step;

  always #5 clk = ~clk;

  fib_sum_checker dut (
    .clk      (clk),
    .rst      (rst),
    .i        (i),
    .n        (n),
    .c        (c),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .expected (expected),
    .step_err (step_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] closed_form(input logic [W-1:0] nn);
    int unsigned v, p;
    v = nn;
    p = (v * (v - 1)) / 2;
    return p[W-1:0];
  endfunction

  task automatic do_reset(input logic [W-1:0] nn);
    rst = 1'b1; i = '0; c = '0; n = nn;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst.done", done, 0);
    chk("rst.pass", pass, 0);
    chk("rst.fail", fail, 0);
    chk("rst.expected", expected, 0);
    chk("rst.step_err", step_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bad_step = 1'b0;
  endtask

  task automatic step(input logic [W-1:0] ni, input logic [W-1:0] nc);
    logic [W-1:0] inc_i, sum_c;
    @(posedge clk); #1;
    inc_i = i + 1'b1;
    sum_c = c + i;
    if (!((ni == i && nc == c) || (ni == inc_i && nc == sum_c))) bad_step = 1'b1;
    i = ni;
    c = nc;
  endtask

  task automatic finish_run(input string tag);
    sb_t e;
    int  cyc;
    bit  got;
    e.tag      = tag;
    e.exp_val  = closed_form(n);
    e.exp_pass = (c == e.exp_val);
    e.exp_serr = bad_step;
    sb_q.push_back(e);
    cyc = 0;
    got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (done) got = 1;
      else cyc++;
    end
    chk({tag, ".done"}, done, 1);
    e = sb_q.pop_front();
    chk({e.tag, ".latency"}, cyc, W + 2);
    chk({e.tag, ".expected"}, expected, e.exp_val);
    chk({e.tag, ".pass"}, pass, e.exp_pass);
    chk({e.tag, ".fail"}, fail, !e.exp_pass);
    chk({e.tag, ".step_err"}, step_err, e.exp_serr);
  endtask

  task automatic run_accum(input string tag, input logic [W-1:0] nn, input bit corrupt,
                           input logic [W-1:0] skip_at, input bit abort);
    logic [W-1:0] ni, nc;
    bit           skipped;
    do_reset(nn);
    while (i < nn) begin
      ni = i + 1'b1;
      nc = c + i;
      skipped = (skip_at != 0) && (i == skip_at);
      if (skipped) ni = i + 2'd2;
      if (corrupt && ni >= nn) nc = nc + 1'b1;
      step(ni, nc);
      if (skipped) begin
        @(negedge clk);
        chk({tag, ".serr_pre"}, step_err, 0);
        @(negedge clk);
        chk({tag, ".serr_post"}, step_err, 1);
      end
    end
    if (abort) begin
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1; i = '0; c = '0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".abort.done"}, done, 0);
      chk({tag, ".abort.expected"}, expected, 0);
      chk({tag, ".abort.step_err"}, step_err, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      bad_step = 1'b0;
      repeat (20) @(negedge clk);
      chk({tag, ".idle.done"}, done, 0);
      chk({tag, ".idle.step_err"}, step_err, 0);
    end else begin
      finish_run(tag);
    end
  endtask

  initial begin
    rst = 1'b1; i = '0; n = '0; c = '0; bad_step = 1'b0;

    run_accum("nominal", 11'd150, 1'b0, 11'd0, 1'b0);
    n = 11'd5;
    repeat (3) @(negedge clk);
    chk("hold.done", done, 1);
    chk("hold.expected", expected, closed_form(11'd150));
    chk("hold.pass", pass, 1);

    do_reset(11'd0);
    finish_run("zero");

    run_accum("wrap", 11'd2047, 1'b0, 11'd0, 1'b0);
    run_accum("corrupt", 11'd150, 1'b1, 11'd0, 1'b0);
    run_accum("illegal", 11'd20, 1'b0, 11'd5, 1'b0);
    run_accum("one", 11'd1, 1'b0, 11'd0, 1'b0);
    run_accum("random", 11'($urandom_range(2, 400)), 1'b0, 11'd0, 1'b0);
    run_accum("abort", 11'd150, 1'b0, 11'd5, 1'b1);
    run_accum("fresh", 11'd150, 1'b0, 11'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
